// File: rtl/role_pkg.sv
// Shared definitions for the role scheduler: FSM states and default sizing.
package role_pkg;

  localparam int unsigned NumReqDefault = 4;
  localparam int unsigned TmoWDefault   = 16;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StRun,
    StAck
  } role_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after last+1, wrapping.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IdxW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdxW-1:0]    last,
  output logic [IdxW-1:0]    winner,
  output logic               valid
);

  localparam int NumI = int'(NUM_REQ);

  logic [IdxW-1:0] cand;

  // Scan from the farthest offset down so the nearest requester after 'last' overwrites.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int off = NumI; off >= 1; off--) begin
      cand = IdxW'((int'(last) + off) % NumI);
      if (req[cand]) begin
        winner = cand;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/role_sched.sv
// Shares one role core among NUM_REQ requesters: round-robin grant, start handshake,
// watchdog abort and a one-cycle ack/err report per job.
module role_sched
  import role_pkg::*;
#(
  parameter  int unsigned NUM_REQ = NumReqDefault,
  parameter  int unsigned TMO_W   = TmoWDefault,
  localparam int unsigned IdW     = $clog2(NUM_REQ)
) (
  input  logic               role_clk,
  input  logic               role_rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] ack,
  output logic               err,
  output logic [IdW-1:0]     grant_id,
  output logic               busy,
  output logic               core_start,
  input  logic               core_ready,
  input  logic               core_done,
  input  logic               core_err,
  output logic               core_abort,
  input  logic [TMO_W-1:0]   tmo_cycles
);

  role_state_e      state_q, state_d;
  logic [IdW-1:0]   grant_q, grant_d;
  logic [IdW-1:0]   last_q, last_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic [IdW-1:0]   arb_winner;
  logic             arb_valid;
  logic             tmo_hit;
  logic [TMO_W-1:0] cnt_inc;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_arbiter (
    .req   (req),
    .last  (last_q),
    .winner(arb_winner),
    .valid (arb_valid)
  );

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign tmo_hit = (tmo_q != '0) && (cnt_q == tmo_q);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    busy_d     = busy_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    core_start = 1'b0;
    core_abort = 1'b0;
    ack        = '0;
    err        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          grant_d = arb_winner;
          busy_d  = 1'b1;
          state_d = StStart;
        end
      end

      StStart: begin
        core_start = 1'b1;
        if (core_ready) begin
          cnt_d   = '0;
          tmo_d   = tmo_cycles;
          state_d = StRun;
        end
      end

      StRun: begin
        cnt_d = cnt_inc;
        // A completion arriving on the timeout cycle is honoured; no abort is issued.
        if (core_done) begin
          err_d   = core_err;
          state_d = StAck;
        end else if (tmo_hit) begin
          core_abort = 1'b1;
          err_d      = 1'b1;
          state_d    = StAck;
        end
      end

      StAck: begin
        ack     = NUM_REQ'(1) << grant_q;
        err     = err_q;
        last_d  = grant_q;
        busy_d  = 1'b0;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge role_clk) begin
    if (role_rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= IdW'(NUM_REQ - 1);
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign busy     = busy_q;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_role_sched.sv
// Self-checking bench for role_sched: directed scenarios plus randomized jobs checked
// against a job-level model (round-robin pick, watchdog/done outcome, ack timing).
module tb_role_sched;

  localparam int N  = 4;
  localparam int TW = 16;

  logic          clk        = 1'b0;
  logic          rst        = 1'b1;
  logic [N-1:0]  req        = '0;
  logic [N-1:0]  ack;
  logic          err;
  logic [1:0]    grant_id;
  logic          busy;
  logic          core_start;
  logic          core_ready = 1'b0;
  logic          core_done  = 1'b0;
  logic          core_err   = 1'b0;
  logic          core_abort;
  logic [TW-1:0] tmo_cycles = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int last_g   = N - 1;

  always #5 clk = ~clk;

  role_sched #(
    .NUM_REQ(N),
    .TMO_W  (TW)
  ) dut (
    .role_clk  (clk),
    .role_rst  (rst),
    .req       (req),
    .ack       (ack),
    .err       (err),
    .grant_id  (grant_id),
    .busy      (busy),
    .core_start(core_start),
    .core_ready(core_ready),
    .core_done (core_done),
    .core_err  (core_err),
    .core_abort(core_abort),
    .tmo_cycles(tmo_cycles)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs are driven 2 time units after the rising edge, outputs sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    int idx;
    for (int k = 1; k <= N; k++) begin
      idx = (last + k) % N;
      if (r[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  // One complete job from IDLE back to IDLE. done_at < 0 means the core never finishes.
  task automatic run_job(input logic [N-1:0] r, input int rdy_dly, input int done_at,
                         input logic cerr, input logic [TW-1:0] tmo);
    int   w;
    logic done_now;
    logic tmo_now;
    logic exp_err;
    w          = rr_pick(r, last_g);
    req        = r;
    core_done  = 1'b0;
    core_ready = (rdy_dly == 0);
    tmo_cycles = tmo;
    settle();
    check_eq("idle_core_start", core_start, 1'b0);
    check_eq("idle_busy", busy, 1'b0);
    tick();
    check_eq("grant_id", grant_id, w[1:0]);
    check_eq("start_strobe", core_start, 1'b1);
    check_eq("start_busy", busy, 1'b1);
    // Owner may drop its request and others may toggle; neither may disturb the job.
    req = N'($urandom);
    for (int i = 0; i < rdy_dly; i++) begin
      core_ready = 1'b0;
      core_done  = 1'($urandom);
      settle();
      check_eq("start_hold", core_start, 1'b1);
      check_eq("start_no_abort", core_abort, 1'b0);
      check_eq("start_no_ack", ack, '0);
      tick();
    end
    core_ready = 1'b1;
    core_done  = 1'b0;
    settle();
    check_eq("start_ready", core_start, 1'b1);
    tick();
    tmo_cycles = TW'($urandom);
    core_ready = 1'($urandom);
    req        = N'($urandom);
    done_now   = 1'b0;
    tmo_now    = 1'b0;
    for (int k = 0; k < 10000; k++) begin
      done_now  = (k == done_at);
      tmo_now   = (tmo != '0) && (k == int'(tmo));
      core_done = done_now;
      core_err  = done_now ? cerr : 1'($urandom);
      settle();
      check_eq("run_abort", core_abort, tmo_now && !done_now);
      check_eq("run_no_start", core_start, 1'b0);
      check_eq("run_no_ack", ack, '0);
      tick();
      if (done_now || tmo_now) break;
    end
    core_done = 1'($urandom);
    core_err  = 1'($urandom);
    exp_err   = done_now ? cerr : 1'b1;
    settle();
    check_eq("ack_onehot", ack, 32'(1) << w);
    check_eq("ack_err", err, exp_err);
    check_eq("ack_busy", busy, 1'b1);
    check_eq("ack_no_abort", core_abort, 1'b0);
    last_g = w;
    tick();
    core_done = 1'b0;
    settle();
    check_eq("post_ack", ack, '0);
    check_eq("post_err", err, 1'b0);
    check_eq("post_busy", busy, 1'b0);
  endtask

  task automatic reset_mid_job(input logic [N-1:0] r, input int run_cycles);
    int w;
    w          = rr_pick(r, last_g);
    req        = r;
    core_ready = 1'b1;
    core_done  = 1'b0;
    tmo_cycles = '0;
    tick();
    tick();
    repeat (run_cycles) tick();
    settle();
    check_eq("pre_rst_busy", busy, 1'b1);
    check_eq("pre_rst_grant", grant_id, w[1:0]);
    check_eq("pre_rst_in_run", core_start, 1'b0);
    rst = 1'b1;
    req = '0;
    tick();
    settle();
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_ack", ack, '0);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_core_start", core_start, 1'b0);
    check_eq("rst_core_abort", core_abort, 1'b0);
    check_eq("rst_grant_id", grant_id, 2'd0);
    rst = 1'b0;
    tick();
    settle();
    check_eq("after_rst_ack", ack, '0);
    check_eq("after_rst_busy", busy, 1'b0);
    last_g = N - 1;
  endtask

  initial begin
    logic [N-1:0]  r;
    logic [TW-1:0] t;
    int            d;
    int            rd;
    repeat (3) tick();
    settle();
    check_eq("reset_busy", busy, 1'b0);
    check_eq("reset_ack", ack, '0);
    check_eq("reset_err", err, 1'b0);
    check_eq("reset_core_start", core_start, 1'b0);
    check_eq("reset_core_abort", core_abort, 1'b0);
    check_eq("reset_grant_id", grant_id, 2'd0);
    rst = 1'b0;
    tick();
    settle();
    check_eq("idle_no_req_busy", busy, 1'b0);

    // Full contention, immediate completion: grants 0,1,2,3,0.
    for (int j = 0; j < 5; j++) run_job(4'b1111, 0, 0, 1'b0, '0);
    check_eq("rr_wrap_last", last_g, 0);
    // Single requester 2, done five cycles into RUN.
    run_job(4'b0100, 0, 5, 1'b0, '0);
    // Watchdog expiry with a silent core.
    run_job(4'b0010, 0, -1, 1'b0, 16'd10);
    // Completion on the watchdog cycle wins; both error polarities.
    run_job(4'b1000, 0, 10, 1'b1, 16'd10);
    run_job(4'b1000, 0, 10, 1'b0, 16'd10);
    // Long ready stall with a short watchdog: no abort in START.
    run_job(4'b0001, 50, 3, 1'b0, 16'd5);
    // Reset during RUN drops the job and restarts arbitration at requester 0.
    reset_mid_job(4'b0100, 4);
    run_job(4'b1111, 0, 2, 1'b1, '0);

    for (int j = 0; j < 40; j++) begin
      r  = N'($urandom_range(1, 15));
      rd = $urandom_range(0, 3);
      if ($urandom_range(0, 2) == 0) t = '0;
      else t = TW'($urandom_range(1, 12));
      if (t == '0) d = $urandom_range(0, 15);
      else if ($urandom_range(0, 1) == 0) d = -1;
      else d = $urandom_range(0, int'(t) + 3);
      run_job(r, rd, d, 1'($urandom), t);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time limit, expected completion");
    $fatal(1);
  end

endmodule
